online_mult_seq_ctrl: RTL and testbench
=======================================

ONLINE_MULT_SEQ_CTRL -- requirements
Module: online_mult_seq_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, width of the fractional-word read address.
REQ-002 Parameter CNT_WIDTH, default 6, width of the digit and iteration counters.
REQ-003 Parameter DELTA, default 3, online delay of the multiplier in iterations (1..7).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 asyn_reset_n  input  1  reset, asynchronous assert and active-low.
REQ-006 start  input  1  begins an operation; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of the current operation.
REQ-008 num_digits  input  CNT_WIDTH  operand and result length N, latched on start.
REQ-009 num_words  input  ADDR_WIDTH  fractional words per iteration W, latched on start.
REQ-010 in_valid / in_ready  input / output  1 / 1  operand digit-pair handshake.
REQ-011 in_digit  input  2  signed operand digit pair {plus, minus}.
REQ-012 p_value_in  input  2  selected digit from the upper-bits datapath.
REQ-013 dp_enable  output  1  datapath enable.
REQ-014 rd_addr  output  ADDR_WIDTH  fractional-word address to the datapath.
REQ-015 shift_in  output  2  digit pair shifted into the datapath.
REQ-016 out_valid / out_ready  output / input  1 / 1  result-digit handshake.
REQ-017 out_digit  output  2  result digit {plus, minus}.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  single-cycle pulse on normal completion.

Function
REQ-020 FSM states: IDLE, LOAD, SWEEP, EMIT, DONE.
REQ-021 IDLE -> LOAD on start=1.
- Latch N and W; W=0 is treated as 1.
- Clear the iteration counter it.
- Exception: N=0 goes IDLE -> DONE.
REQ-022 LOAD, it<N: in_ready=1; on in_valid&in_ready, register in_digit into shift_in and go to SWEEP.
REQ-023 LOAD, it>=N: in_ready=0; load shift_in=2'b00 and go to SWEEP the next cycle without waiting.
REQ-024 SWEEP: dp_enable=1 for exactly W cycles; rd_addr=0,1,...,W-1, one step per cycle.
REQ-025 SWEEP, last cycle (rd_addr=W-1): rd_addr returns to 0 and it increments.
- it >= DELTA before the increment: go to EMIT.
- Otherwise: go to LOAD.
REQ-026 SWEEP, cycle with rd_addr=0 and it>=DELTA: register p_value_in into out_digit.
REQ-027 EMIT: out_valid=1 with out_digit stable until out_ready=1; on acceptance, clear out_valid and go to the next state.
- Digits emitted == N: go to DONE.
- Otherwise: go to LOAD.
REQ-028 DONE: done=1 for one cycle, then IDLE.
REQ-029 Total iterations per operation: N+DELTA; result digits emitted: exactly N.
REQ-030 Outside SWEEP: dp_enable=0 and rd_addr=0.
REQ-031 in_ready and out_valid are never high in the same cycle.
REQ-032 abort=1 in any non-IDLE state:
- Next cycle is IDLE with out_valid=0 and in_ready=0.
- done is not pulsed.
- abort has priority over every other transition.
REQ-033 start while not IDLE: ignored; num_digits/num_words changes after latching have no effect.
REQ-034 Counters: it is CNT_WIDTH+3 bits wide, so N+DELTA never wraps.

Reset
REQ-035 While asyn_reset_n=0, immediately and regardless of clk:
- FSM in IDLE; rd_addr=0; shift_in=0; out_digit=0.
- All handshake, enable, busy and done outputs = 0.
REQ-036 Reset deasserted mid-operation: the block restarts in IDLE; no partial digit is emitted.

Verification
REQ-037 N=2, W=3, DELTA=3, in_valid always 1, out_ready always 1:
- Exactly 2 in handshakes, 5 SWEEPs of rd_addr 0,1,2.
- 2 out_valid pulses carrying p_value_in sampled at rd_addr=0 of iterations 3 and 4.
- Then a 1-cycle done.
REQ-038 in_valid low for 4 cycles in the second LOAD: FSM holds LOAD with dp_enable=0 and rd_addr=0, then resumes.
REQ-039 out_ready low for 5 cycles: out_valid stays 1 and out_digit constant; no SWEEP occurs until acceptance.
REQ-040 N=0: done asserts 1 cycle after start; no in_ready, dp_enable or out_valid activity.
REQ-041 abort asserted mid-SWEEP at rd_addr=1:
- Next cycle IDLE, rd_addr=0, no done.
- A following start with N=1, W=1 completes normally.
REQ-042 asyn_reset_n pulsed low between clock edges during EMIT: outputs clear asynchronously and FSM is in IDLE on the first edge after release.

Source files
------------

// File: rtl/online_mult_seq_ctrl_if.sv
// Handshake/bus bundle between the online-multiplier controller and its surroundings.
// master: operation requester, operand source, result sink and datapath (drives start..out_ready).
// slave : the sequencing controller (drives in_ready, datapath controls, result, status).
interface online_mult_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int CNT_WIDTH  = 6
);
  logic                  start;
  logic                  abort;
  logic [CNT_WIDTH-1:0]  num_digits;
  logic [ADDR_WIDTH-1:0] num_words;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_digit;
  logic [1:0]            p_value_in;
  logic                  dp_enable;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]            shift_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            out_digit;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, num_digits, num_words, in_valid, in_digit, p_value_in, out_ready,
    input  in_ready, dp_enable, rd_addr, shift_in, out_valid, out_digit, busy, done
  );

  modport slave (
    input  start, abort, num_digits, num_words, in_valid, in_digit, p_value_in, out_ready,
    output in_ready, dp_enable, rd_addr, shift_in, out_valid, out_digit, busy, done
  );
endinterface

// File: rtl/online_mult_seq_ctrl.sv
// Sequencer for an online (MSD-first) multiplier: per iteration it loads one operand digit
// pair, sweeps W fractional words through the datapath, and after DELTA iterations emits one
// result digit per iteration. Ports: clk, asyn_reset_n, bus (slave modport of the _if bundle).
// Backpressure: stalls in LOAD until in_valid, holds EMIT until out_ready; abort cancels at once.
module online_mult_seq_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int CNT_WIDTH  = 6,
  parameter int DELTA      = 3
) (
  input  logic                 clk,
  input  logic                 asyn_reset_n,
  online_mult_seq_ctrl_if.slave bus
);

  // Iteration counter is 3 bits wider than N so N+DELTA (DELTA<=7) never wraps.
  localparam int IT_W = CNT_WIDTH + 3;
  localparam logic [IT_W-1:0] DELTA_IT = IT_W'(DELTA);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SWEEP = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [ADDR_WIDTH-1:0] w_q, w_d;
  logic [IT_W-1:0]       it_q, it_d;
  logic [CNT_WIDTH-1:0]  emit_q, emit_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            shift_q, shift_d;
  logic [1:0]            out_q, out_d;

  logic                  in_rdy;
  logic                  out_vld;
  logic                  dp_en;
  logic                  operand_left;
  logic                  emitting;

  // Operand digits remain while it < N; afterwards zeros are fed so the tail digits can drain.
  assign operand_left = (it_q < IT_W'(n_q));
  // Result digits exist once the online delay has been covered.
  assign emitting     = (it_q >= DELTA_IT);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    w_d     = w_q;
    it_d    = it_q;
    emit_d  = emit_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    out_d   = out_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    dp_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d     = bus.num_digits;
          w_d     = (bus.num_words == '0) ? ADDR_WIDTH'(1) : bus.num_words;
          it_d    = '0;
          emit_d  = '0;
          addr_d  = '0;
          state_d = (bus.num_digits == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        if (operand_left) begin
          in_rdy = 1'b1;
          if (bus.in_valid) begin
            shift_d = bus.in_digit;
            state_d = S_SWEEP;
          end
        end else begin
          shift_d = 2'b00;
          state_d = S_SWEEP;
        end
      end

      S_SWEEP: begin
        dp_en = 1'b1;
        // The selected digit is valid on the first word of the sweep.
        if ((addr_q == '0) && emitting) begin
          out_d = bus.p_value_in;
        end
        if (addr_q == (w_q - ADDR_WIDTH'(1))) begin
          addr_d  = '0;
          it_d    = it_q + IT_W'(1);
          state_d = emitting ? S_EMIT : S_LOAD;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end

      S_EMIT: begin
        out_vld = 1'b1;
        if (bus.out_ready) begin
          emit_d  = emit_q + CNT_WIDTH'(1);
          state_d = ((emit_q + CNT_WIDTH'(1)) == n_q) ? S_DONE : S_LOAD;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel wins over every other transition; leave the address at rest.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      w_q     <= '0;
      it_q    <= '0;
      emit_q  <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      w_q     <= w_d;
      it_q    <= it_d;
      emit_q  <= emit_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      out_q   <= out_d;
    end
  end

  // Handshakes and status decode directly from state, so reset clears them immediately.
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.dp_enable = dp_en;
  assign bus.rd_addr   = addr_q;
  assign bus.shift_in  = shift_q;
  assign bus.out_digit = out_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_online_mult_seq_ctrl.sv
// Testbench for online_mult_seq_ctrl: directed scenarios plus randomized operations, each
// checked against a transaction-level model (operand queue, per-sweep sampled digits,
// ordering rules between loads, sweeps and emits).
module tb_online_mult_seq_ctrl;
  localparam int AW     = 7;
  localparam int CW     = 6;
  localparam int DELTA  = 3;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic asyn_reset_n;
  always #5 clk = ~clk;

  online_mult_seq_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  online_mult_seq_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .DELTA(DELTA)) dut (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_inrdy"}, 32'(bus.in_ready), 0);
    chk({tag, "_outvld"},32'(bus.out_valid), 0);
    chk({tag, "_dpen"},  32'(bus.dp_enable), 0);
    chk({tag, "_addr"},  32'(bus.rd_addr), 0);
  endtask

  // One operation of N digits over W words. stall_in: in_valid held low for that many
  // LOAD cycles once the first operand is taken. stall_out: out_ready held low for that many
  // cycles on the first emit. abort_sweep>=0: abort at rd_addr=1 of that sweep.
  // reset_emit: asynchronous reset pulse between edges during the first emit.
  task automatic run_op(input int n, input int w, input int vpct, input int rpct,
                        input int stall_in, input int stall_out,
                        input int abort_sweep, input int reset_emit);
    logic [1:0] in_q[$];
    logic [1:0] p_at[$];
    logic [1:0] exp_d;
    int in_hs, sweeps, pos, emits, dones, done_cyc, sin, sout, weff, exp_sweeps;
    bit finished, cut, prev_done;
    logic o_rdy, o_vld, o_dp, o_busy, o_done;
    logic [AW-1:0] o_addr;
    logic [1:0] o_shift, o_out;

    in_hs = 0; sweeps = 0; pos = 0; emits = 0; dones = 0; done_cyc = -1;
    sin = 0; sout = 0; finished = 0; cut = 0; prev_done = 0;
    weff = (w == 0) ? 1 : w;
    exp_sweeps = (n == 0) ? 0 : n + DELTA;

    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      o_rdy = bus.in_ready; o_vld = bus.out_valid; o_dp = bus.dp_enable;
      o_busy = bus.busy; o_done = bus.done; o_addr = bus.rd_addr;
      o_shift = bus.shift_in; o_out = bus.out_digit;

      if (c > 0) begin
        if (!o_busy) begin
          chk("done_before_idle", 32'(prev_done), 1);
          finished = 1;
          break;
        end
        chk("rdy_vld_excl", 32'(o_rdy & o_vld), 0);
        if (!o_dp) chk("addr_outside_sweep", 32'(o_addr), 0);
        if (o_rdy) begin
          chk("load_order", in_hs, sweeps);
          chk("load_needed", 32'(in_hs < n), 1);
        end
        if (o_vld) begin
          chk("emit_order", sweeps, DELTA + emits + 1);
          exp_d = (DELTA + emits < p_at.size()) ? p_at[DELTA + emits] : 2'bxx;
          chk("out_digit", 32'(o_out), 32'(exp_d));
        end
        if (o_dp) begin
          chk("rd_addr_sweep", 32'(o_addr), pos);
          if (pos == 0) begin
            chk("sweep_after_load", in_hs, (sweeps < n) ? sweeps + 1 : n);
            chk("sweep_after_emit", emits, (sweeps > DELTA) ? sweeps - DELTA : 0);
          end
          exp_d = (sweeps < n) ? ((sweeps < in_q.size()) ? in_q[sweeps] : 2'bxx) : 2'b00;
          chk("shift_in", 32'(o_shift), 32'(exp_d));
        end
        if (o_done) begin
          dones++;
          done_cyc = c;
        end
        prev_done = o_done;

        if (reset_emit != 0 && o_vld) begin
          bus.start = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
          #1 asyn_reset_n = 1'b0;
          #1;
          idle_outputs("async_rst");
          chk("async_rst_out_digit", 32'(bus.out_digit), 0);
          chk("async_rst_shift_in", 32'(bus.shift_in), 0);
          #1 asyn_reset_n = 1'b1;
          @(negedge clk);
          idle_outputs("after_rst");
          cut = 1;
          break;
        end
      end

      // drive inputs for the coming rising edge
      if (c == 0) begin
        bus.start = 1'b1;
        bus.num_digits = CW'(n);
        bus.num_words = AW'(w);
      end else begin
        // Starts and operand-length changes while busy must be ignored.
        bus.start = ($urandom_range(0, 3) == 0);
        bus.num_digits = CW'($urandom);
        bus.num_words = AW'($urandom);
      end
      bus.in_valid = ($urandom_range(0, 99) < vpct);
      bus.in_digit = 2'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < rpct);
      bus.p_value_in = 2'($urandom);
      bus.abort = 1'b0;
      if (o_rdy && in_hs == 1 && sin < stall_in) begin
        bus.in_valid = 1'b0;
        sin++;
      end
      if (o_vld && emits == 0 && sout < stall_out) begin
        bus.out_ready = 1'b0;
        sout++;
      end
      if (abort_sweep >= 0 && o_dp && sweeps == abort_sweep && o_addr == AW'(1)) begin
        bus.abort = 1'b1;
        bus.start = 1'b0;
      end

      // model bookkeeping for the coming edge
      if (o_rdy && bus.in_valid) begin
        in_q.push_back(bus.in_digit);
        in_hs++;
      end
      if (o_dp) begin
        if (pos == 0) p_at.push_back(bus.p_value_in);
        pos++;
        if (pos == weff) begin
          pos = 0;
          sweeps++;
        end
      end
      if (o_vld && bus.out_ready) emits++;

      if (bus.abort) begin
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        idle_outputs("after_abort");
        cut = 1;
        break;
      end
    end

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.abort = 1'b0;

    if (cut) begin
      chk("cut_no_done", dones, 0);
    end else begin
      chk("op_finished", 32'(finished), 1);
      chk("in_handshakes", in_hs, n);
      chk("sweep_count", sweeps, exp_sweeps);
      chk("emit_count", emits, n);
      chk("done_pulses", dones, 1);
      if (n == 0) chk("n0_done_latency", done_cyc, 1);
    end
    @(negedge clk);
  endtask

  initial begin
    asyn_reset_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_digits = '0; bus.num_words = '0;
    bus.in_valid = 1'b0; bus.in_digit = 2'b00; bus.p_value_in = 2'b00; bus.out_ready = 1'b0;
    #1;
    idle_outputs("reset");
    chk("reset_shift_in", 32'(bus.shift_in), 0);
    chk("reset_out_digit", 32'(bus.out_digit), 0);
    #22 asyn_reset_n = 1'b1;
    @(negedge clk);
    idle_outputs("post_reset");

    run_op(2, 3, 100, 100, 0, 0, -1, 0);    // basic: 2 loads, 5 sweeps, 2 emits
    run_op(3, 2, 100, 100, 4, 0, -1, 0);    // operand stall in second LOAD
    run_op(2, 2, 100, 100, 0, 5, -1, 0);    // result stall on first emit
    run_op(0, 3, 100, 100, 0, 0, -1, 0);    // empty operation
    run_op(4, 3, 100, 100, 0, 0, 1, 0);     // abort mid-sweep
    run_op(1, 1, 100, 100, 0, 0, -1, 0);    // normal op after abort
    run_op(3, 2, 100, 100, 0, 3, -1, 1);    // async reset during EMIT
    run_op(2, 1, 100, 100, 0, 0, -1, 0);    // normal op after reset
    run_op(1, 0, 100, 100, 0, 0, -1, 0);    // W=0 behaves as W=1

    for (int k = 0; k < 8; k++) begin
      run_op($urandom_range(1, 8), $urandom_range(0, 5),
             $urandom_range(40, 100), $urandom_range(40, 100), 0, 0, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
